// File: rtl/coremem_pkg.sv
// Shared types and constants for the two-master core-memory arbiter.
// Master 0 is instruction fetch, master 1 is the LSU data port.
package coremem_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  typedef logic [0:0] master_id_t;

  localparam master_id_t MASTER_IFETCH = 1'b0;
  localparam master_id_t MASTER_LSU    = 1'b1;

endpackage : coremem_pkg

// File: rtl/coremem_id_fifo.sv
// In-order queue of master IDs for granted-but-unanswered transactions.
// Push and pop may happen in the same cycle; pointers wrap modulo DEPTH.
module coremem_id_fifo
  import coremem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  master_id_t               id_i,
  input  logic                     pop_i,
  output master_id_t               head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  master_id_t               mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [$clog2(DEPTH):0]   count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= MASTER_IFETCH;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= id_i;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : coremem_id_fifo

// File: rtl/coremem_arbiter.sv
// Round-robin two-master arbiter in front of the core-memory port, with a
// request lock while the port stalls and in-order response routing.
module coremem_arbiter
  import coremem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NUM_MASTERS-1:0]                   m_req_i,
  input  logic [NUM_MASTERS-1:0]                   m_we_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  output logic [NUM_MASTERS-1:0]                   m_gnt_o,
  output logic [NUM_MASTERS-1:0]                   m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    m_rdata_o,
  output logic                                     s_req_o,
  output logic                                     s_we_o,
  output logic [ADDR_WIDTH-1:0]                    s_addr_o,
  output logic [DATA_WIDTH-1:0]                    s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                  s_be_o,
  input  logic                                     s_gnt_i,
  input  logic                                     s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
  output logic                                     err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  master_id_t        sel;
  master_id_t        last_grant_q;
  master_id_t        lock_id_q;
  logic              lock_q;
  logic              err_q;
  logic              grant;
  logic              resp;
  master_id_t        head;
  logic [CNT_W-1:0]  count;

  // A locked master keeps the port so a stalled request is never swapped out.
  always_comb begin
    sel = MASTER_IFETCH;
    if (lock_q)                sel = lock_id_q;
    else if (&m_req_i)         sel = ~last_grant_q;
    else if (m_req_i[MASTER_LSU]) sel = MASTER_LSU;
  end

  assign s_req_o   = m_req_i[sel] && (count < CNT_W'(MAX_OUTSTANDING));
  assign s_we_o    = m_we_i[sel];
  assign s_addr_o  = m_addr_i[sel];
  assign s_wdata_o = m_wdata_i[sel];
  assign s_be_o    = m_be_i[sel];

  assign grant = s_req_o & s_gnt_i;
  assign resp  = s_rvalid_i && (count != '0);

  always_comb begin
    m_gnt_o         = '0;
    m_gnt_o[sel]    = grant;
    m_rvalid_o      = '0;
    m_rvalid_o[head] = resp;
  end

  assign m_rdata_o = s_rdata_i;

  coremem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .id_i    (sel),
    .pop_i   (resp),
    .head_o  (head),
    .count_o (count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= MASTER_LSU;
      lock_q       <= 1'b0;
      lock_id_q    <= MASTER_IFETCH;
      err_q        <= 1'b0;
    end else begin
      if (grant) last_grant_q <= sel;
      if (grant && lock_q) begin
        lock_q <= 1'b0;
      end else if (s_req_o && !s_gnt_i) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end
      if (s_rvalid_i && (count == '0)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule : coremem_arbiter

// File: tb/tb_coremem_arbiter.sv
// Directed bench for coremem_arbiter: a per-cycle vector table plus
// hand-written reset, contention, lock and reset-clears-error sequences.
module tb_coremem_arbiter;
  import coremem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic [1:0]                m_req_i;
  logic [1:0]                m_we_i;
  logic [1:0][AW-1:0]        m_addr_i;
  logic [1:0][DW-1:0]        m_wdata_i;
  logic [1:0][DW/8-1:0]      m_be_i;
  logic [1:0]                m_gnt_o;
  logic [1:0]                m_rvalid_o;
  logic [DW-1:0]             m_rdata_o;
  logic                      s_req_o;
  logic                      s_we_o;
  logic [AW-1:0]             s_addr_o;
  logic [DW-1:0]             s_wdata_o;
  logic [DW/8-1:0]           s_be_o;
  logic                      s_gnt_i;
  logic                      s_rvalid_i;
  logic [DW-1:0]             s_rdata_i;
  logic                      err_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  coremem_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .m_req_i    (m_req_i),
    .m_we_i     (m_we_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_be_i     (m_be_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_be_o     (s_be_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .err_o      (err_o)
  );

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        exp_sreq;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic        exp_sel;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
    @(negedge clk_i);
    m_req_i    = req;
    s_gnt_i    = gnt;
    s_rvalid_i = rv;
    s_rdata_i  = rdata;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni     = 1'b0;
    m_req_i    = 2'b00;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic check_sel(input string name, input logic s);
    check({name, "_addr"},  s_addr_o,  m_addr_i[s]);
    check({name, "_wdata"}, s_wdata_o, m_wdata_i[s]);
    check({name, "_we"},    32'(s_we_o), 32'(m_we_i[s]));
    check({name, "_be"},    32'(s_be_o), 32'(m_be_i[s]));
  endtask

  initial begin
    m_addr_i  = '{32'h0000_2000, 32'h0000_1000};
    m_wdata_i = '{32'hBBBB_0001, 32'hAAAA_0000};
    m_be_i    = '{4'h3, 4'hF};
    m_we_i    = 2'b10;

    //           req    gnt   rv    rdata         sreq  gnt    rv     sel   err
    vecs[0]  = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 1'b1, 1'b1, 32'h11111111, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    vecs[5]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 1'b1, 32'h22222222, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 1'b1, 32'h33333333, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 1'b1, 32'h44444444, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 32'h55555555, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 1'b1};

    // Reset state
    do_reset();
    #1;
    check("rst_gnt",    32'(m_gnt_o),    32'h0);
    check("rst_rvalid", 32'(m_rvalid_o), 32'h0);
    check("rst_sreq",   32'(s_req_o),    32'h0);
    check("rst_err",    32'(err_o),      32'h0);

    // Vector table: single master, contention, full, in-order routing, stray rvalid
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      check($sformatf("v%0d_sreq", i),   32'(s_req_o),    32'(vecs[i].exp_sreq));
      check($sformatf("v%0d_gnt", i),    32'(m_gnt_o),    32'(vecs[i].exp_gnt));
      check($sformatf("v%0d_rvalid", i), 32'(m_rvalid_o), 32'(vecs[i].exp_rv));
      check($sformatf("v%0d_err", i),    32'(err_o),      32'(vecs[i].exp_err));
      check_sel($sformatf("v%0d", i), vecs[i].exp_sel);
      if (vecs[i].exp_rv != 2'b00)
        check($sformatf("v%0d_rdata", i), m_rdata_o, vecs[i].rdata);
    end

    // err stays set until reset, then clears
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("err_sticky", 32'(err_o), 32'h1);
    do_reset();
    #1;
    check("err_cleared", 32'(err_o), 32'h0);

    // Contention from reset: grants alternate 01,10,01,10 (rvalid keeps a slot free)
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check("rr_0", 32'(m_gnt_o), 32'h1);
    drive(2'b11, 1'b1, 1'b1, 32'h0);
    check("rr_1", 32'(m_gnt_o), 32'h2);
    check("rr_1_rv", 32'(m_rvalid_o), 32'h1);
    drive(2'b11, 1'b1, 1'b1, 32'h0);
    check("rr_2", 32'(m_gnt_o), 32'h1);
    check("rr_2_rv", 32'(m_rvalid_o), 32'h2);
    drive(2'b11, 1'b1, 1'b1, 32'h0);
    check("rr_3", 32'(m_gnt_o), 32'h2);
    check("rr_3_rv", 32'(m_rvalid_o), 32'h1);

    // Lock: master 1 stalls 3 cycles, then both request; master 1 must win
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2'b10, 1'b0, 1'b0, 32'h0);
      check($sformatf("lock_c%0d_addr", c), s_addr_o, m_addr_i[1]);
      check($sformatf("lock_c%0d_gnt", c), 32'(m_gnt_o), 32'h0);
    end
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check("lock_c3_addr", s_addr_o, m_addr_i[1]);
    check("lock_c3_gnt", 32'(m_gnt_o), 32'h2);
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check("lock_after_gnt", 32'(m_gnt_o), 32'h1);

    // Response in flight across a reset counts as unexpected
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 32'h0);
    check("post_rst_rv", 32'(m_rvalid_o), 32'h0);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("post_rst_err", 32'(err_o), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_coremem_arbiter
